// File: rtl/phys_pkg.sv
// Shared definitions for the physics step scheduler: phase encoding and
// default timing/frame parameters.
package phys_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_VEL   = 3'd3,
        ST_POS   = 3'd4,
        ST_COLL  = 3'd5,
        ST_STORE = 3'd6
    } phase_e;

    localparam int unsigned DEFAULT_RELOAD     = 98;
    localparam int unsigned DEFAULT_NUM_BODIES = 4;

    // A von Neumann machine needs its own fetch slot; Harvard fetches during LOAD.
    function automatic phase_e first_phase(input logic vn_mode);
        return vn_mode ? ST_FETCH : ST_LOAD;
    endfunction

endpackage

// File: rtl/phys_tick_divider.sv
// Free-running down-counter producing a one-cycle tick every RELOAD+1 cycles;
// reload_now restarts the period so the first tick lands RELOAD+1 cycles later.
module phys_tick_divider #(
    parameter int unsigned RELOAD = 98
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload_now,
    output logic tick
);

    localparam logic [6:0] RELOAD_V = 7'(RELOAD);

    logic [6:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RELOAD_V;
        end else if (reload_now || (count_q == 7'd0)) begin
            count_q <= RELOAD_V;
        end else begin
            count_q <= count_q - 7'd1;
        end
    end

    assign tick = (count_q == 7'd0);

endmodule

// File: rtl/phys_step_scheduler.sv
// Frame sequencer for a physics step engine: walks each body through
// fetch/load/velocity/position/collision/store, one phase per divider tick.
module phys_step_scheduler
    import phys_pkg::*;
#(
    parameter int unsigned RELOAD     = DEFAULT_RELOAD,
    parameter int unsigned NUM_BODIES = DEFAULT_NUM_BODIES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt,
    input  logic       von_neumann,
    output logic       busy,
    output logic [2:0] phase,
    output logic [1:0] body_idx,
    output logic       ifetch_en,
    output logic       mem_rd_en,
    output logic       alu_vel_en,
    output logic       alu_pos_en,
    output logic       coll_en,
    output logic       mem_wr_en,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam logic [1:0] LAST_BODY = 2'(NUM_BODIES - 1);

    phase_e     state_q, state_d;
    logic [1:0] body_q, body_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       halt_pend_q, halt_pend_d;
    logic       mode_q, mode_d;
    logic       reload_now;
    logic       tick;

    phys_tick_divider #(.RELOAD(RELOAD)) u_tick_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .reload_now (reload_now),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            body_q      <= 2'd0;
            frame_cnt_q <= 8'd0;
            halt_pend_q <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            body_q      <= body_d;
            frame_cnt_q <= frame_cnt_d;
            halt_pend_q <= halt_pend_d;
            mode_q      <= mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        body_d      = body_q;
        frame_cnt_d = frame_cnt_q;
        halt_pend_d = halt_pend_q;
        mode_d      = mode_q;
        reload_now  = 1'b0;
        ifetch_en   = 1'b0;
        mem_rd_en   = 1'b0;
        alu_vel_en  = 1'b0;
        alu_pos_en  = 1'b0;
        coll_en     = 1'b0;
        mem_wr_en   = 1'b0;
        frame_done  = 1'b0;

        if (state_q == ST_IDLE) begin
            halt_pend_d = 1'b0;
            // A halt arriving with start cancels the launch outright.
            if (start && !halt) begin
                reload_now = 1'b1;
                mode_d     = von_neumann;
                state_d    = first_phase(von_neumann);
                body_d     = 2'd0;
            end
        end else begin
            if (halt) begin
                halt_pend_d = 1'b1;
            end
            if (tick) begin
                case (state_q)
                    ST_FETCH: begin
                        ifetch_en = 1'b1;
                        state_d   = ST_LOAD;
                    end
                    ST_LOAD: begin
                        mem_rd_en = 1'b1;
                        ifetch_en = !mode_q;
                        state_d   = ST_VEL;
                    end
                    ST_VEL: begin
                        alu_vel_en = 1'b1;
                        state_d    = ST_POS;
                    end
                    ST_POS: begin
                        alu_pos_en = 1'b1;
                        state_d    = ST_COLL;
                    end
                    ST_COLL: begin
                        coll_en = 1'b1;
                        state_d = ST_STORE;
                    end
                    ST_STORE: begin
                        mem_wr_en = 1'b1;
                        if (body_q == LAST_BODY) begin
                            frame_done  = 1'b1;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            body_d      = 2'd0;
                            mode_d      = von_neumann;
                            if (halt_pend_q || halt) begin
                                state_d     = ST_IDLE;
                                halt_pend_d = 1'b0;
                            end else begin
                                state_d = first_phase(von_neumann);
                            end
                        end else begin
                            body_d  = body_q + 2'd1;
                            state_d = first_phase(mode_q);
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign phase     = state_q;
    assign body_idx  = body_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_phys_step_scheduler.sv
// Scoreboard bench for phys_step_scheduler with RELOAD=3 (tick period 4) and
// four bodies per frame; every strobe event is matched against a queued expectation.
module tb_phys_step_scheduler;

    localparam int EW = 52;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  ph;
        logic [1:0]  body;
        logic [5:0]  strb;   // {ifetch, mem_rd, vel, pos, coll, wr}
        logic        fd;
        logic [7:0]  fc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       von_neumann = 1'b0;
    logic       busy;
    logic [2:0] phase;
    logic [1:0] body_idx;
    logic       ifetch_en, mem_rd_en, alu_vel_en, alu_pos_en, coll_en, mem_wr_en;
    logic       frame_done;
    logic [7:0] frame_cnt;

    logic [EW-1:0] exp_q[$];
    int cyc = 0;
    int start_edge = 0;
    int tick_n = 0;
    int checks = 0;
    int errors = 0;

    phys_step_scheduler #(.RELOAD(3), .NUM_BODIES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .von_neumann (von_neumann),
        .busy        (busy),
        .phase       (phase),
        .body_idx    (body_idx),
        .ifetch_en   (ifetch_en),
        .mem_rd_en   (mem_rd_en),
        .alu_vel_en  (alu_vel_en),
        .alu_pos_en  (alu_pos_en),
        .coll_en     (coll_en),
        .mem_wr_en   (mem_wr_en),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    // Clock and cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected events for one frame; limit truncates the frame (for reset mid-frame).
    task automatic push_frame(input bit vn, input logic [7:0] fc, input int limit);
        ev_t e;
        int  n = 0;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 6; s++) begin
                if (s == 0 && !vn) continue;
                if (n >= limit) return;
                n++;
                tick_n++;
                e.cyc  = 32'(start_edge + 4 * tick_n);
                e.ph   = 3'(s + 1);
                e.body = 2'(b);
                case (s)
                    0:       e.strb = 6'b100000;
                    1:       e.strb = vn ? 6'b010000 : 6'b110000;
                    2:       e.strb = 6'b001000;
                    3:       e.strb = 6'b000100;
                    4:       e.strb = 6'b000010;
                    default: e.strb = 6'b000001;
                endcase
                e.fd = (s == 5 && b == 3);
                e.fc = fc;
                exp_q.push_back(e);
            end
        end
    endtask

    // Driver tasks
    task automatic do_start(input bit vn);
        @(negedge clk);
        von_neumann = vn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start_edge = cyc;
        tick_n = 0;
        start = 1'b0;
    endtask

    task automatic pulse_halt_after(input int n);
        repeat (n) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d events outstanding, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] fc);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(fc));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [5:0] strb;
        ev_t got, e;
        strb = {ifetch_en, mem_rd_en, alu_vel_en, alu_pos_en, coll_en, mem_wr_en};
        if (rst_n && (strb != 6'd0 || frame_done)) begin
            got = '{cyc: 32'(cyc + 1), ph: phase, body: body_idx, strb: strb,
                    fd: frame_done, fc: frame_cnt};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc=%0d ph=%0d body=%0d strb=%b fd=%b, expected none",
                         got.cyc, got.ph, got.body, got.strb, got.fd);
            end else begin
                e = exp_q.pop_front();
                if (got != e) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d ph=%0d body=%0d strb=%b fd=%b fc=%0d, expected cyc=%0d ph=%0d body=%0d strb=%b fd=%b fc=%0d",
                             got.cyc, got.ph, got.body, got.strb, got.fd, got.fc,
                             e.cyc, e.ph, e.body, e.strb, e.fd, e.fc);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_phase", 32'(phase), 32'd0);
        chk("reset_body", 32'(body_idx), 32'd0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_strobes", 32'({ifetch_en, mem_rd_en, alu_vel_en, alu_pos_en, coll_en, mem_wr_en, frame_done}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // von Neumann frame, halt mid-frame, stray start ignored while busy
        do_start(1'b1);
        push_frame(1'b1, 8'd0, 99);
        pulse_halt_after(30);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(200, "vn_frame");
        chk_idle("vn_frame", 8'd1);

        // Harvard frame: no FETCH, LOAD strobes both ports
        do_start(1'b0);
        push_frame(1'b0, 8'd1, 99);
        pulse_halt_after(20);
        wait_drain(200, "harvard_frame");
        chk_idle("harvard_frame", 8'd2);

        // start and halt together in IDLE stay idle
        @(negedge clk);
        start = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        halt = 1'b0;
        repeat (10) @(negedge clk);
        chk("start_halt_busy", 32'(busy), 32'd0);

        // Mode changes only take effect at the frame boundary
        do_start(1'b0);
        push_frame(1'b0, 8'd2, 99);
        push_frame(1'b1, 8'd3, 99);
        repeat (30) @(negedge clk);
        von_neumann = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() < 12) break;
        end
        von_neumann = 1'b0;
        pulse_halt_after(1);
        wait_drain(400, "mode_switch");
        chk_idle("mode_switch", 8'd4);

        // Reset during POS of body 2 aborts everything
        do_start(1'b1);
        push_frame(1'b1, 8'd4, 15);
        wait_drain(200, "pre_reset");
        @(negedge clk);
        chk("pre_reset_phase", 32'(phase), 32'd4);
        chk("pre_reset_body", 32'(body_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_phase", 32'(phase), 32'd0);
        chk("mid_reset_body", 32'(body_idx), 32'd0);
        chk("mid_reset_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // 256 Harvard frames: frame_cnt wraps 255 -> 0
        do_start(1'b0);
        for (int f = 0; f < 256; f++) push_frame(1'b0, 8'(f), 99);
        for (int i = 0; i < 22000; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() < 10) break;
        end
        pulse_halt_after(1);
        wait_drain(22000, "wrap");
        chk_idle("wrap", 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phys_step_scheduler.md
PHYS_STEP_SCHEDULER -- requirements
Module: phys_step_scheduler

Interface
REQ-001 SHALL have parameter RELOAD, default 98, meaning tick divider reload value (7-bit; tick period RELOAD+1 clk cycles).
REQ-002 SHALL have parameter NUM_BODIES, default 4, meaning bodies per frame (legal 1..4).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin continuous frame execution from IDLE.
REQ-006 SHALL have port halt  input  1  request stop at next frame boundary.
REQ-007 SHALL have port von_neumann  input  1  1 = shared fetch/data port (separate FETCH state); 0 = Harvard.
REQ-008 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-009 SHALL have port phase  output  3  current state encoding.
REQ-010 SHALL have port body_idx  output  2  body being processed.
REQ-011 SHALL have port ifetch_en, mem_rd_en, alu_vel_en, alu_pos_en, coll_en, mem_wr_en  output  1 each  one-cycle datapath strobes.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each frame.
REQ-013 SHALL have port frame_cnt  output  8  completed-frame count.

Function
REQ-014 SHALL encode states IDLE=0, FETCH=1, LOAD=2, VEL=3, POS=4, COLL=5, STORE=6; phase shows the current state.
REQ-015 SHALL run a down-counter from RELOAD to 0, asserting internal tick for the one cycle the count is 0, then reloading; counter free-runs except as in REQ-016.
REQ-016 SHALL, in IDLE with start=1 and no halt pending, leave IDLE at the next edge, reload the counter to RELOAD and latch von_neumann; first tick occurs RELOAD+1 cycles later.
REQ-017 SHALL leave IDLE to FETCH if latched mode=1, else to LOAD; body_idx=0.
REQ-018 SHALL advance the non-IDLE state only on an edge where tick=1: FETCH->LOAD->VEL->POS->COLL->STORE.
REQ-019 SHALL assert the strobe of the current state for exactly the cycle tick=1: FETCH->ifetch_en, LOAD->mem_rd_en (plus ifetch_en when Harvard), VEL->alu_vel_en, POS->alu_pos_en, COLL->coll_en, STORE->mem_wr_en; never two memory-port strobes together in von Neumann mode.
REQ-020 SHALL, at STORE tick with body_idx<NUM_BODIES-1, increment body_idx and return to FETCH (von Neumann) or LOAD (Harvard).
REQ-021 SHALL, at STORE tick with body_idx=NUM_BODIES-1, pulse frame_done, increment frame_cnt (255 wraps to 0), clear body_idx, re-latch von_neumann, and go to IDLE if halt pending, else to the first state of the new frame.
REQ-022 SHALL capture halt into a sticky pending flag at any cycle while busy; flag clears on entering IDLE.
REQ-023 SHALL ignore start while busy; in IDLE, simultaneous start and halt SHALL remain in IDLE.
REQ-024 SHALL ignore changes on von_neumann except at the latch points of REQ-016/REQ-021.
REQ-025 SHALL keep frame_cnt across IDLE periods; only reset clears it.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, phase=0, body_idx=0, frame_cnt=0, counter=RELOAD, halt-pending=0, latched mode=0, busy=0 and all strobes and frame_done=0, independent of clk.
REQ-027 SHALL, on reset asserted mid-frame, abort with no further strobes; first post-reset activity requires a new start.

Structure
REQ-028 SHALL place state encoding, default RELOAD and NUM_BODIES in shared package phys_pkg.
REQ-029 SHALL implement the reload counter as sub-module phys_tick_divider (inputs clk, rst_n, reload_now; output tick).

Verification (RELOAD=3, NUM_BODIES=4, tick period 4)
REQ-030 SHALL cover: start at cycle 0, von_neumann=1 -> first strobe ifetch_en at cycle 4; 24 ticks later frame_done at cycle 96, frame_cnt=1.
REQ-031 SHALL cover: von_neumann=0 -> FETCH never entered, LOAD strobes both mem_rd_en and ifetch_en, frame_done at cycle 80.
REQ-032 SHALL cover: halt pulsed one cycle mid-frame -> frame completes, frame_done pulses, next cycle busy=0, phase=0.
REQ-033 SHALL cover: von_neumann toggled mid-frame -> sequence unchanged until frame boundary, new mode from next frame.
REQ-034 SHALL cover: 256 frames -> frame_cnt wraps 255->0 with frame_done still pulsing.
REQ-035 SHALL cover: rst_n low during POS of body 2 -> outputs zero immediately; no strobes until new start.
